// File: rtl/const_pkg.sv
// ---------------------------------------------------------------------------
// const_pkg
//   Shared single-bit constants so that drive levels read as intent
//   (HIGH/LOW) rather than bare literals.
// ---------------------------------------------------------------------------
package const_pkg;

  localparam logic LOW  = 1'b0;
  localparam logic HIGH = 1'b1;

endpackage : const_pkg

// File: rtl/fta_bus_pkg.sv
// ---------------------------------------------------------------------------
// fta_bus_pkg
//   32-bit FTA command bus types shared by fabric masters and slaves,
//   plus the state type of the WISHBONE-to-FTA bridge.
//
//   fta_cmd_request32_t  : master -> fabric command (one beat)
//   fta_cmd_response32_t : fabric -> master response, matched by tid
//   fta_cti_t            : cycle type; CLASSIC = no response expected for
//                          writes, ERC = write that returns a response
//   fta_err_t            : response status; IRQ marks an interrupt message
//                          that carries no transaction completion
// ---------------------------------------------------------------------------
package fta_bus_pkg;

  typedef enum logic [2:0] {
    CLASSIC = 3'd0,
    FIXED   = 3'd1,
    INCR    = 3'd2,
    ERC     = 3'd7
  } fta_cti_t;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    DECERR = 2'd1,
    SLVERR = 2'd2,
    IRQ    = 2'd3
  } fta_err_t;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    fta_cti_t    cti;
    logic [3:0]  sel;
    logic [31:0] padr;
    logic [31:0] dat;
    logic [12:0] tid;
    logic [3:0]  pri;
  } fta_cmd_request32_t;

  typedef struct packed {
    logic        ack;
    logic [12:0] tid;
    fta_err_t    err;
    logic [31:0] dat;
  } fta_cmd_response32_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    ACK  = 3'd3,
    ERR  = 3'd4
  } wb2fta_state_t;

endpackage : fta_bus_pkg

// File: rtl/wb2fta_bridge32.sv
// ---------------------------------------------------------------------------
// wb2fta_bridge32
//   Classic WISHBONE slave that turns each WISHBONE cycle into one tagged
//   FTA request. Reads (and writes when ERC_WRITES=1) wait for the response
//   whose tid matches the issued one; fire-and-forget writes ack at once.
//   IRQ response messages are forwarded as a one-cycle irq_o pulse.
//
//   Handshake: a WISHBONE transfer is offered while wb_cyc_i & wb_stb_i are
//   high and is sampled only in IDLE; it completes with exactly one cycle of
//   wb_ack_o or wb_err_o. Dropping wb_cyc_i before completion abandons it
//   silently. wb_stall_o is high whenever the bridge cannot sample a new
//   transfer. On the FTA side req.cyc is high for exactly one cycle per
//   request; resp.ack marks a valid response beat (no back-pressure).
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   wb_cyc_i/stb_i/we_i/sel_i/adr_i/dat_i : WISHBONE request
//   wb_dat_o/ack_o/err_o/stall_o          : WISHBONE completion
//   req           : FTA request (all-zero outside the REQ state)
//   resp          : FTA response
//   irq_o         : one-cycle pulse per IRQ response
//   dbg_state_o   : current FSM state, for debug/checkers
// ---------------------------------------------------------------------------
module wb2fta_bridge32
  import fta_bus_pkg::*;
  import const_pkg::*;
#(
  parameter logic [12:0] TID_BASE   = 13'h0100,
  parameter logic [3:0]  PRI        = 4'd7,
  parameter logic        ERC_WRITES = 1'b0,
  parameter int          TIMEOUT    = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [3:0]          wb_sel_i,
  input  logic [31:0]         wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  output logic [31:0]         wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                wb_stall_o,
  output fta_cmd_request32_t  req,
  input  fta_cmd_response32_t resp,
  output logic                irq_o,
  output wb2fta_state_t       dbg_state_o
);

  // Counter only has to hold 0..TIMEOUT-1: WAIT is left when it hits TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  wb2fta_state_t      state_q, state_d;
  logic [3:0]         seq_q, seq_d;
  logic [12:0]        tid_q, tid_d;
  logic               we_q, we_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  fta_cmd_request32_t req_q, req_d;
  logic [31:0]        dat_q, dat_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic               irq_q, irq_d;

  logic               resp_match;
  logic               resp_ok;

  // IRQ messages may reuse any tid, so they are excluded from completion.
  assign resp_match = resp.ack && (resp.tid == tid_q) && (resp.err != IRQ);
  assign resp_ok    = (resp.err == OKAY);

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    tid_d   = tid_q;
    we_d    = we_q;
    cnt_d   = '0;
    req_d   = '0;
    dat_d   = dat_q;

    case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          state_d    = REQ;
          we_d       = wb_we_i;
          tid_d      = {TID_BASE[12:4], seq_q};
          req_d.cyc  = HIGH;
          req_d.stb  = HIGH;
          req_d.we   = wb_we_i;
          req_d.cti  = (wb_we_i && ERC_WRITES) ? ERC : CLASSIC;
          req_d.sel  = wb_sel_i;
          req_d.padr = wb_adr_i;
          req_d.dat  = wb_dat_i;
          req_d.tid  = {TID_BASE[12:4], seq_q};
          req_d.pri  = PRI;
        end
      end

      REQ: begin
        // The request is already on the bus this cycle, even if aborted.
        seq_d = seq_q + 4'd1;
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else if (!we_q || ERC_WRITES) begin
          state_d = WAIT;
        end else begin
          state_d = ACK;
        end
      end

      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else if (resp_match) begin
          // A match in the timeout cycle still completes normally.
          state_d = resp_ok ? ACK : ERR;
          if (!we_q && resp_ok) begin
            dat_d = resp.dat;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = ERR;
        end
      end

      ACK:     state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ack_d = (state_d == ACK) ? HIGH : LOW;
    err_d = (state_d == ERR) ? HIGH : LOW;
    irq_d = (resp.ack && (resp.err == IRQ)) ? HIGH : LOW;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      seq_q   <= '0;
      tid_q   <= '0;
      we_q    <= LOW;
      cnt_q   <= '0;
      req_q   <= '0;
      dat_q   <= '0;
      ack_q   <= LOW;
      err_q   <= LOW;
      irq_q   <= LOW;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      tid_q   <= tid_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      irq_q   <= irq_d;
    end
  end

  assign req         = req_q;
  assign wb_dat_o    = dat_q;
  assign wb_ack_o    = ack_q;
  assign wb_err_o    = err_q;
  assign wb_stall_o  = (state_q != IDLE);
  assign irq_o       = irq_q;
  assign dbg_state_o = state_q;

endmodule : wb2fta_bridge32

// File: tb/tb_wb2fta_bridge32.sv
// ---------------------------------------------------------------------------
// tb_wb2fta_bridge32
//   Two bridges: dut_a (fire-and-forget writes) and dut_b (ERC writes), both
//   with an 8-cycle timeout. One bus master model drives whichever is
//   selected by use_b; the other sees idle inputs.
// ---------------------------------------------------------------------------
module tb_wb2fta_bridge32;
  import fta_bus_pkg::*;

  localparam logic [12:0] TID_BASE = 13'h0100;
  localparam logic [3:0]  PRI      = 4'd7;
  localparam int          TMO      = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- master-side signals ----------------
  logic                m_cyc, m_stb, m_we;
  logic [3:0]          m_sel;
  logic [31:0]         m_adr, m_dat;
  fta_cmd_response32_t m_resp;
  logic                use_b;

  logic a_cyc, a_stb, b_cyc, b_stb;
  fta_cmd_response32_t a_resp, b_resp;
  logic [31:0] a_dat, b_dat;
  logic a_ack, b_ack, a_err, b_err, a_stall, b_stall, a_irq, b_irq;
  fta_cmd_request32_t a_req, b_req;
  wb2fta_state_t a_state, b_state;

  logic [31:0] s_dat;
  logic s_ack, s_err, s_stall, s_irq;
  fta_cmd_request32_t s_req;
  wb2fta_state_t s_state;

  always_comb begin
    a_cyc = m_cyc; a_stb = m_stb; a_resp = m_resp;
    b_cyc = 1'b0;  b_stb = 1'b0;  b_resp = '0;
    if (use_b) begin
      b_cyc = m_cyc; b_stb = m_stb; b_resp = m_resp;
      a_cyc = 1'b0;  a_stb = 1'b0;  a_resp = '0;
    end
    s_dat   = use_b ? b_dat   : a_dat;
    s_ack   = use_b ? b_ack   : a_ack;
    s_err   = use_b ? b_err   : a_err;
    s_stall = use_b ? b_stall : a_stall;
    s_irq   = use_b ? b_irq   : a_irq;
    s_req   = use_b ? b_req   : a_req;
    s_state = use_b ? b_state : a_state;
  end

  wb2fta_bridge32 #(.TID_BASE(TID_BASE), .PRI(PRI), .ERC_WRITES(1'b0), .TIMEOUT(TMO)) dut_a (
    .clk(clk), .rst(rst), .wb_cyc_i(a_cyc), .wb_stb_i(a_stb), .wb_we_i(m_we),
    .wb_sel_i(m_sel), .wb_adr_i(m_adr), .wb_dat_i(m_dat), .wb_dat_o(a_dat),
    .wb_ack_o(a_ack), .wb_err_o(a_err), .wb_stall_o(a_stall), .req(a_req),
    .resp(a_resp), .irq_o(a_irq), .dbg_state_o(a_state)
  );

  wb2fta_bridge32 #(.TID_BASE(TID_BASE), .PRI(PRI), .ERC_WRITES(1'b1), .TIMEOUT(TMO)) dut_b (
    .clk(clk), .rst(rst), .wb_cyc_i(b_cyc), .wb_stb_i(b_stb), .wb_we_i(m_we),
    .wb_sel_i(m_sel), .wb_adr_i(m_adr), .wb_dat_i(m_dat), .wb_dat_o(b_dat),
    .wb_ack_o(b_ack), .wb_err_o(b_err), .wb_stall_o(b_stall), .req(b_req),
    .resp(b_resp), .irq_o(b_irq), .dbg_state_o(b_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int seq_m [2];            // requests issued per bridge since reset
  logic [31:0] rd_m [2];    // last read data returned per bridge
  logic [33:0] exp_q [$];   // {ack, err, wb_dat_o} expected per transaction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock; irq_o must reflect whether an IRQ response was on the bus.
  task automatic tick();
    logic e;
    e = !rst && m_resp.ack && (m_resp.err == IRQ);
    @(negedge clk);
    chk("irq_o", {127'b0, s_irq}, {127'b0, e});
  endtask

  function automatic fta_cmd_request32_t exp_req(input logic we, input logic [3:0] sel,
                                                 input logic [31:0] adr, input logic [31:0] dat,
                                                 input int seq, input logic erc);
    fta_cmd_request32_t r;
    r      = '0;
    r.cyc  = 1'b1;
    r.stb  = 1'b1;
    r.we   = we;
    r.cti  = (we && erc) ? ERC : CLASSIC;
    r.sel  = sel;
    r.padr = adr;
    r.dat  = dat;
    r.tid  = (TID_BASE & 13'h1FF0) | 13'(seq % 16);
    r.pri  = PRI;
    return r;
  endfunction

  task automatic set_resp(input logic ack, input logic [12:0] tid, input fta_err_t err,
                          input logic [31:0] dat);
    m_resp.ack = ack; m_resp.tid = tid; m_resp.err = err; m_resp.dat = dat;
  endtask

  task automatic wb_drive(input logic cyc, input logic we, input logic [3:0] sel,
                          input logic [31:0] adr, input logic [31:0] dat);
    m_cyc = cyc; m_stb = cyc; m_we = we; m_sel = sel; m_adr = adr; m_dat = dat;
  endtask

  task automatic sel_dut(input logic b);
    use_b = b;
    #1;
  endtask

  // Full transaction on the selected bridge; completion expectations come
  // from exp_q. noise injects a wrong-tid response then an IRQ response.
  task automatic run_txn(input string tag, input logic we, input logic [3:0] sel,
                         input logic [31:0] adr, input logic [31:0] dat, input fta_err_t rerr,
                         input logic [31:0] rdat, input int delay, input logic noise);
    int d;
    logic waits;
    fta_cmd_request32_t er;
    logic [33:0] ex;
    d     = use_b ? 1 : 0;
    waits = !we || use_b;
    er    = exp_req(we, sel, adr, dat, seq_m[d], use_b);
    ex    = exp_q.pop_front();
    wb_drive(1'b1, we, sel, adr, dat);
    tick();
    chk($sformatf("%s req", tag), 128'(s_req), 128'(er));
    chk($sformatf("%s stall", tag), {127'b0, s_stall}, 128'd1);
    seq_m[d]++;
    tick();
    chk($sformatf("%s req_drop", tag), 128'(s_req), 128'd0);
    if (waits) begin
      chk($sformatf("%s early_ack", tag), {126'b0, s_ack, s_err}, 128'd0);
      for (int i = 0; i < delay; i++) begin
        set_resp(1'b0, '0, OKAY, '0);
        if (noise && i == 0) set_resp(1'b1, er.tid ^ 13'h005, OKAY, 32'h5A5A_5A5A);
        if (noise && i == 1) set_resp(1'b1, er.tid, IRQ, 32'hA5A5_A5A5);
        tick();
        chk($sformatf("%s wait_quiet", tag), {126'b0, s_ack, s_err}, 128'd0);
      end
      set_resp(1'b1, er.tid, rerr, rdat);
      tick();
      set_resp(1'b0, '0, OKAY, '0);
    end
    chk($sformatf("%s ack_err", tag), {126'b0, s_ack, s_err}, {126'b0, ex[33:32]});
    chk($sformatf("%s rdata", tag), {96'b0, s_dat}, {96'b0, ex[31:0]});
    rd_m[d] = ex[31:0];
    wb_drive(1'b0, 1'b0, 4'h0, '0, '0);
    tick();
    chk($sformatf("%s idle", tag), {125'b0, s_ack, s_err, s_stall}, 128'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk($sformatf("%s req", tag), 128'(s_req), 128'd0);
    chk($sformatf("%s flags", tag), {124'b0, s_ack, s_err, s_stall, s_irq}, 128'd0);
    chk($sformatf("%s dat", tag), {96'b0, s_dat}, 128'd0);
    chk($sformatf("%s state", tag), {125'b0, s_state}, {125'b0, IDLE});
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        dut;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    fta_err_t    rerr;
    logic [31:0] rdat;
    int          delay;
    logic        noise;
    logic        exp_ack;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vec [8];

  // ---------------- stimulus ----------------
  initial begin : main
    fta_cmd_request32_t er;
    logic [12:0] tid;
    int n;
    logic we, ea, ee, nz;
    logic [3:0] sel;
    logic [31:0] adr, dat, rd, erd;
    fta_err_t e;
    int dly, d;

    vec[0] = '{1'b0, 1'b0, 4'hF, 32'h0000_1000, 32'h0, OKAY,   32'hDEAD_BEEF, 3, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vec[1] = '{1'b0, 1'b1, 4'hC, 32'h0000_1004, 32'h1234_5678, OKAY, 32'h0, 0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vec[2] = '{1'b0, 1'b0, 4'hF, 32'h0000_2000, 32'h0, SLVERR, 32'h0BAD_F00D, 1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vec[3] = '{1'b1, 1'b1, 4'hF, 32'h0000_3000, 32'hAABB_CCDD, OKAY, 32'h0, 2, 1'b0, 1'b1, 1'b0, 32'h0};
    vec[4] = '{1'b1, 1'b1, 4'h3, 32'h0000_3004, 32'h1122_3344, DECERR, 32'h0, 0, 1'b0, 1'b0, 1'b1, 32'h0};
    vec[5] = '{1'b1, 1'b0, 4'hF, 32'h0000_3008, 32'h0, OKAY,   32'h0102_0304, 4, 1'b1, 1'b1, 1'b0, 32'h0102_0304};
    vec[6] = '{1'b0, 1'b0, 4'hF, 32'h0000_100C, 32'h0, OKAY,   32'hCAFE_F00D, 0, 1'b0, 1'b1, 1'b0, 32'hCAFE_F00D};
    vec[7] = '{1'b1, 1'b1, 4'h1, 32'h0000_300C, 32'h0000_00EE, OKAY, 32'h0, 1, 1'b0, 1'b1, 1'b0, 32'h0102_0304};

    use_b = 1'b0;
    wb_drive(1'b0, 1'b0, 4'h0, '0, '0);
    m_resp = '0;
    seq_m[0] = 0; seq_m[1] = 0; rd_m[0] = '0; rd_m[1] = '0;

    // Reset state of both bridges.
    repeat (3) tick();
    sel_dut(1'b0); chk_zero("reset_a");
    sel_dut(1'b1); chk_zero("reset_b");
    rst = 1'b0;
    sel_dut(1'b0);
    tick();

    // Table-driven transactions (entry 0 also exercises tid filter + IRQ).
    foreach (vec[i]) begin
      sel_dut(vec[i].dut);
      exp_q.push_back({vec[i].exp_ack, vec[i].exp_err, vec[i].exp_rd});
      run_txn($sformatf("vec%0d", i), vec[i].we, vec[i].sel, vec[i].adr, vec[i].dat,
              vec[i].rerr, vec[i].rdat, vec[i].delay, vec[i].noise);
    end

    // Back-to-back writes with stb held: requests 3 cycles apart, then an
    // abort in REQ (request still issues, no ack follows).
    sel_dut(1'b0);
    wb_drive(1'b1, 1'b1, 4'hF, 32'h0000_5000, 32'h5555_0001);
    er = exp_req(1'b1, 4'hF, 32'h0000_5000, 32'h5555_0001, seq_m[0], 1'b0);
    tick(); chk("b2b req1", 128'(s_req), 128'(er));
    tick(); chk("b2b ack1", {126'b0, s_ack, s_req.cyc}, {126'b0, 2'b10});
    tick(); chk("b2b gap", {126'b0, s_ack, s_req.cyc}, 128'd0);
    er = exp_req(1'b1, 4'hF, 32'h0000_5000, 32'h5555_0001, seq_m[0] + 1, 1'b0);
    tick(); chk("b2b req2", 128'(s_req), 128'(er));
    wb_drive(1'b0, 1'b0, 4'h0, '0, '0);
    tick(); chk("req_abort", {125'b0, s_ack, s_err, s_stall}, 128'd0);
    tick(); chk("req_abort quiet", {126'b0, s_ack, s_err}, 128'd0);
    seq_m[0] += 2;

    // Back-to-back IRQ responses while idle.
    set_resp(1'b1, 13'h0ABC, IRQ, 32'h0);
    tick(); tick();
    set_resp(1'b0, '0, OKAY, '0);
    tick(); tick();
    chk("irq no stall", {126'b0, s_ack, s_stall}, 128'd0);

    // 17 reads: tid low bits walk through a full wrap.
    for (int k = 0; k < 17; k++) begin
      rd = $urandom;
      exp_q.push_back({1'b1, 1'b0, rd});
      run_txn($sformatf("wrap%0d", k), 1'b0, 4'hF, 32'h0000_6000 + 32'(k * 4), $urandom,
              OKAY, rd, 0, 1'b0);
    end

    // Timeout: read with no response errors after 8 WAIT cycles.
    wb_drive(1'b1, 1'b0, 4'hF, 32'h0000_4000, 32'h0);
    er = exp_req(1'b0, 4'hF, 32'h0000_4000, 32'h0, seq_m[0], 1'b0);
    tid = er.tid;
    tick(); chk("tmo req", 128'(s_req), 128'(er));
    seq_m[0]++;
    tick();
    n = 0;
    while (s_err !== 1'b1 && n < 20) begin
      chk("tmo no_ack", {127'b0, s_ack}, 128'd0);
      tick();
      n++;
    end
    chk("tmo cycles", 128'(n), 128'(TMO));
    chk("tmo err", {127'b0, s_err}, 128'd1);
    chk("tmo dat", {96'b0, s_dat}, {96'b0, rd_m[0]});
    wb_drive(1'b0, 1'b0, 4'h0, '0, '0);
    tick(); chk("tmo idle", {125'b0, s_ack, s_err, s_stall}, 128'd0);
    set_resp(1'b1, tid, OKAY, 32'h9999_9999);
    tick();
    set_resp(1'b0, '0, OKAY, '0);
    tick(); chk("tmo late", {126'b0, s_ack, s_err}, 128'd0);
    chk("tmo late dat", {96'b0, s_dat}, {96'b0, rd_m[0]});

    // Abort in WAIT, then a stale response that must be ignored.
    wb_drive(1'b1, 1'b0, 4'hF, 32'h0000_7000, 32'h0);
    er = exp_req(1'b0, 4'hF, 32'h0000_7000, 32'h0, seq_m[0], 1'b0);
    tid = er.tid;
    tick(); chk("abort req", 128'(s_req), 128'(er));
    seq_m[0]++;
    tick(); tick();
    wb_drive(1'b0, 1'b0, 4'h0, '0, '0);
    tick(); chk("abort idle", {125'b0, s_ack, s_err, s_stall}, 128'd0);
    set_resp(1'b1, tid, OKAY, 32'h7777_7777);
    tick();
    set_resp(1'b0, '0, OKAY, '0);
    tick(); chk("abort stale", {126'b0, s_ack, s_err}, 128'd0);
    chk("abort dat", {96'b0, s_dat}, {96'b0, rd_m[0]});

    // Randomised transactions against the reference model.
    for (int k = 0; k < 40; k++) begin
      sel_dut(1'($urandom_range(0, 1)));
      d   = use_b ? 1 : 0;
      we  = 1'($urandom_range(0, 1));
      sel = 4'($urandom);
      adr = $urandom;
      dat = $urandom;
      rd  = $urandom;
      case ($urandom_range(0, 5))
        0:       e = DECERR;
        1:       e = SLVERR;
        default: e = OKAY;
      endcase
      dly = $urandom_range(0, 4);
      nz  = (dly >= 2) && ($urandom_range(0, 1) == 1);
      if (we && !use_b) begin
        ea = 1'b1; ee = 1'b0; erd = rd_m[d];
      end else begin
        ea  = (e == OKAY);
        ee  = !ea;
        erd = (!we && e == OKAY) ? rd : rd_m[d];
      end
      exp_q.push_back({ea, ee, erd});
      run_txn($sformatf("rnd%0d", k), we, sel, adr, dat, e, rd, dly, nz);
    end

    // Reset in the middle of WAIT clears everything; late response ignored.
    sel_dut(1'b0);
    exp_q.push_back({1'b1, 1'b0, 32'hFEED_FACE});
    run_txn("pre_rst", 1'b0, 4'hF, 32'h0000_8000, 32'h0, OKAY, 32'hFEED_FACE, 1, 1'b0);
    wb_drive(1'b1, 1'b0, 4'hF, 32'h0000_8004, 32'h0);
    er = exp_req(1'b0, 4'hF, 32'h0000_8004, 32'h0, seq_m[0], 1'b0);
    tid = er.tid;
    tick(); tick();
    rst = 1'b1;
    wb_drive(1'b0, 1'b0, 4'h0, '0, '0);
    tick();
    rst = 1'b0;
    seq_m[0] = 0; seq_m[1] = 0; rd_m[0] = '0; rd_m[1] = '0;
    chk_zero("mid_rst");
    set_resp(1'b1, tid, OKAY, 32'h4444_4444);
    tick();
    set_resp(1'b0, '0, OKAY, '0);
    tick(); chk("rst late", {126'b0, s_ack, s_err}, 128'd0);
    chk("rst late dat", {96'b0, s_dat}, 128'd0);
    exp_q.push_back({1'b1, 1'b0, 32'h3141_5926});
    run_txn("post_rst", 1'b0, 4'hF, 32'h0000_9000, 32'h0, OKAY, 32'h3141_5926, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_wb2fta_bridge32

// File: doc/wb2fta_bridge32.md
Name: wb2fta_bridge32

Overview:
- Classic-WISHBONE slave to 32-bit FTA-bus master bridge; the inverse of the FTA-to-WISHBONE bridge.
- Lets legacy WISHBONE masters (debug cores, DMA, simple CPUs) issue requests onto the FTA fabric.
- Accepts one WISHBONE cycle at a time and issues a single FTA request with a tagged tid.
- For reads and ERC writes, waits for the tid-matched FTA response, then acks or errors the WISHBONE cycle. Also forwards FTA IRQ response messages as an interrupt pulse.

Parameters:
- TID_BASE, 13'h0100: upper tid bits [12:4] come from TID_BASE[12:4]; low 4 bits are a sequence number.
- PRI, 4'd7: priority placed in every issued request.
- ERC_WRITES, 1'b0: 1 = writes are issued with cti=ERC and wait for a response; 0 = fire-and-forget writes.
- TIMEOUT, 1023: cycles spent in WAIT before the bridge returns wb_err_o.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- wb_cyc_i  in  1  WB cycle
- wb_stb_i  in  1  WB strobe
- wb_we_i  in  1  WB write enable
- wb_sel_i  in  4  WB byte selects
- wb_adr_i  in  32  WB address
- wb_dat_i  in  32  WB write data
- wb_dat_o  out  32  WB read data
- wb_ack_o  out  1  WB ack
- wb_err_o  out  1  WB error
- wb_stall_o  out  1  busy indication for pipelined masters
- req  out  fta_cmd_request32_t  FTA request to fabric
- resp  in  fta_cmd_response32_t  FTA response from fabric
- irq_o  out  1  one-cycle pulse per IRQ response

Behaviour:
- Reset values:
  - state=IDLE, seq=0, timeout count=0.
  - req all-zero.
  - wb_ack_o=0, wb_err_o=0, wb_dat_o=0, irq_o=0.
  - Reset mid-operation abandons any outstanding request; a late response is ignored because its tid cannot match while in IDLE.
- States:
  - IDLE: if wb_cyc_i&wb_stb_i, capture we/sel/adr/dat and go to REQ.
  - REQ: drive req for exactly one cycle.
    - Fields: cyc=1, stb=1, we, sel, padr=adr, dat, tid={TID_BASE[12:4],seq}, pri=PRI.
    - cti=ERC if (we&ERC_WRITES), else CLASSIC.
    - Next state: WAIT if (!we | ERC_WRITES), else ACK.
    - seq increments modulo 16 on every REQ.
  - WAIT: match on resp.ack && resp.tid==issued tid && resp.err!=IRQ.
    - On match: latch resp.dat into wb_dat_o (reads only). Go to ACK if err==OKAY, else ERR.
    - Timeout count reaches TIMEOUT: go to ERR.
    - Responses with non-matching tid are ignored.
  - ACK: wb_ack_o=1 for one cycle, then IDLE.
  - ERR: wb_err_o=1 for one cycle, then IDLE.
- Outputs outside REQ: req is all-zero (cyc=0) in every state other than REQ.
- Latency:
  - Non-ERC write: stb sampled at cycle 0, req.cyc at cycle 1, wb_ack_o at cycle 2.
  - Read: wb_ack_o comes 1 cycle after the matching resp.ack.
- Outputs are registered. wb_stall_o = (state!=IDLE).
- Back-to-back: the master may keep stb high after ack. The next transfer is sampled in IDLE on the cycle after ACK/ERR, so minimum spacing is 3 cycles.
- Abort: if wb_cyc_i drops in REQ or WAIT, go to IDLE without ack/err.
  - In REQ, the request still issues that cycle.
  - A later matching response is discarded because the state is no longer WAIT.
- Timeout counter:
  - Clears on entry to WAIT and increments each WAIT cycle.
  - If a match arrives in the same cycle the timeout is reached, the match wins.
- IRQ:
  - resp.ack && resp.err==IRQ gives irq_o=1 on the next cycle, in any state, including during WAIT.
  - An IRQ response never completes a transaction.
  - Back-to-back IRQ responses give back-to-back pulses.
- wb_dat_o:
  - Holds its last value until the next read completes.
  - Is unchanged on writes and on errors; for errors the bus returns dat that is not used.

Decomposition:
- fta_bus_pkg: fta_cmd_request32_t, fta_cmd_response32_t, ERC/CLASSIC cti codes, OKAY/IRQ err codes.
- Add wb2fta_state_t (IDLE, REQ, WAIT, ACK, ERR) to fta_bus_pkg.
- LOW/HIGH come from const_pkg.
- No sub-module; the timeout counter is inline.

Test Plan:
- Read: WB read adr=32'h0000_1000.
  - Expect req.cyc for 1 cycle with tid=13'h0100.
  - Bench returns resp ack, tid=13'h0100, dat=32'hDEADBEEF, OKAY two cycles later.
  - Expect wb_ack_o one cycle after that, with wb_dat_o=32'hDEADBEEF.
- Write, ERC_WRITES=0: sel=4'hC, dat=32'h12345678.
  - Expect req.we=1, cti=CLASSIC at cycle 1 and wb_ack_o at cycle 2, with no response needed.
- Write, ERC_WRITES=1:
  - Expect cti=ERC and no ack until the matching response arrives.
  - Response with err!=OKAY → wb_err_o one cycle.
- Tid filter and IRQ: during a read WAIT, inject a response with tid=13'h0105, then an IRQ response, then the matching tid.
  - Expect no ack for the first, irq_o one pulse for the second, ack only for the third.
- Timeout: TIMEOUT=8, read with no response.
  - Expect wb_err_o 8 WAIT cycles after entry.
  - A late matching response afterwards is ignored.
- Seq wrap and abort:
  - 17 reads → tid low bits go 0..F,0.
  - Drop wb_cyc_i in WAIT → IDLE with no ack; the stale response is ignored.
  - Assert rst mid-WAIT → all outputs zero next cycle.
